// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle logic/arithmetic, serial shifts (1 bit/cycle), shift-add MUL.
// Results and flags are registered and held until the consumer takes them.
module alu_pipe #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             c_out,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [3:0]           op_q;
  logic [WIDTH-1:0]     work_q;
  logic [2*WIDTH-1:0]   prod_q;
  logic [WIDTH-1:0]     out_q;
  logic                 cout_q, zero_q, neg_q, ovf_q, valid_q;

  logic                 accept, isShift, isMul, multi;
  logic [CW-1:0]        shAmt;
  logic [WIDTH-1:0]     bOp;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     res_d;
  logic                 cy_d, ov_d;
  logic [WIDTH-1:0]     stepRes_d;
  logic                 stepCy_d;
  logic [WIDTH:0]       mulSum;
  logic [2*WIDTH-1:0]   prodNext_d;

  assign in_ready  = (state_q == IDLE) && (!valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != IDLE);
  assign out_valid = valid_q;
  assign out       = out_q;
  assign c_out     = cout_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;

  // Decode and evaluate the request as presented; only used on the accept edge.
  always_comb begin
    isShift = alu_sel[3] && (alu_sel[2:0] <= 3'b100);
    isMul   = (alu_sel == 4'b1110);
    if (alu_sel == 4'b1100)
      shAmt = CW'(b_in % WIDTH_V);
    else if (b_in >= WIDTH_V)
      shAmt = CW'(WIDTH);
    else
      shAmt = b_in[CW-1:0];
    multi = isMul || (isShift && (shAmt != '0));

    bOp  = (alu_sel == 4'b0001) ? ~b_in : b_in;
    sum  = {1'b0, a_in} + {1'b0, bOp} + {{WIDTH{1'b0}}, c_in};
    res_d = a_in;
    cy_d  = 1'b0;
    ov_d  = 1'b0;
    case (alu_sel)
      4'b0000, 4'b0001: begin
        res_d = sum[WIDTH-1:0];
        cy_d  = sum[WIDTH];
        ov_d  = (a_in[WIDTH-1] == bOp[WIDTH-1]) && (sum[WIDTH-1] != a_in[WIDTH-1]);
      end
      4'b0010: res_d = a_in | b_in;
      4'b0011: res_d = a_in & b_in;
      4'b0100: res_d = a_in ^ b_in;
      4'b0101: res_d = ~(a_in | b_in);
      4'b0110: res_d = ~(a_in & b_in);
      4'b0111: res_d = ~(a_in ^ b_in);
      4'b1101: res_d = ~a_in;
      4'b1111: res_d = b_in;
      default: res_d = a_in;
    endcase
  end

  // One iteration of the serial shifter and of the shift-add multiplier.
  always_comb begin
    case (op_q)
      4'b1010: begin stepRes_d = {work_q[WIDTH-2:0], 1'b0};         stepCy_d = work_q[WIDTH-1]; end
      4'b1011: begin stepRes_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]}; stepCy_d = work_q[0];     end
      4'b1100: begin stepRes_d = {work_q[WIDTH-2:0], work_q[WIDTH-1]}; stepCy_d = work_q[WIDTH-1]; end
      default: begin stepRes_d = {1'b0, work_q[WIDTH-1:1]};         stepCy_d = work_q[0];       end
    endcase
    mulSum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, work_q} : '0);
    prodNext_d = {mulSum, prod_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      work_q  <= '0;
      prod_q  <= '0;
      out_q   <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      if (valid_q && out_ready)
        valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (!multi) begin
              out_q   <= res_d;
              cout_q  <= cy_d;
              zero_q  <= (res_d == '0);
              neg_q   <= res_d[WIDTH-1];
              ovf_q   <= ov_d;
              valid_q <= 1'b1;
            end else if (isMul) begin
              state_q <= MUL;
              work_q  <= a_in;
              prod_q  <= {{WIDTH{1'b0}}, b_in};
              cnt_q   <= CW'(WIDTH);
            end else begin
              state_q <= SHIFT;
              op_q    <= alu_sel;
              work_q  <= a_in;
              cnt_q   <= shAmt;
            end
          end
        end
        SHIFT: begin
          if (cnt_q == CW'(1)) begin
            out_q   <= stepRes_d;
            cout_q  <= stepCy_d;
            zero_q  <= (stepRes_d == '0);
            neg_q   <= stepRes_d[WIDTH-1];
            ovf_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            work_q <= stepRes_d;
            cnt_q  <= cnt_q - CW'(1);
          end
        end
        MUL: begin
          if (cnt_q == CW'(1)) begin
            out_q   <= prodNext_d[WIDTH-1:0];
            cout_q  <= |prodNext_d[2*WIDTH-1:WIDTH];
            zero_q  <= (prodNext_d[WIDTH-1:0] == '0);
            neg_q   <= prodNext_d[WIDTH-1];
            ovf_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            prod_q <= prodNext_d;
            cnt_q  <= cnt_q - CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: the driver pushes model results at accept,
// a monitor pops and compares whenever a result is presented.
module tb_alu_pipe;

  localparam int W = 16;

  logic         clk, rst, in_valid, in_ready, c_in;
  logic         out_valid, out_ready, c_out, zero, neg, ovf, busy;
  logic [3:0]   alu_sel;
  logic [W-1:0] a_in, b_in, out;

  typedef struct {
    logic [W-1:0] res;
    logic         cy, z, n, v;
    int           off;
    int           acc;
  } exp_t;

  exp_t sb[$];
  exp_t head;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   pending = 0;
  bit   randReady = 0;
  bit   randBit = 1;
  bit   readyForce = 1;

  alu_pipe #(.WIDTH(W), .SEL_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_sel(alu_sel), .a_in(a_in), .b_in(b_in), .c_in(c_in),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .c_out(c_out), .zero(zero), .neg(neg), .ovf(ovf), .busy(busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) randBit = ($urandom_range(0, 3) != 0);
  assign out_ready = randReady ? randBit : readyForce;

  // Reference: plain arithmetic on the opcode rules; off = edges after accept until valid.
  function automatic exp_t model(input logic [3:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c);
    exp_t e;
    longint full, sfull;
    logic [W-1:0] bb;
    int n;
    e.res = '0; e.cy = 0; e.v = 0; e.off = 0; e.acc = 0;
    n = (b >= W) ? W : int'(b);
    case (sel)
      4'd0, 4'd1: begin
        bb = (sel == 4'd1) ? ~b : b;
        full  = longint'(a) + longint'(bb) + longint'(c);
        sfull = longint'($signed(a)) + longint'($signed(bb)) + longint'(c);
        e.res = full[W-1:0];
        e.cy  = (full >= 65536);
        e.v   = (sfull > 32767) || (sfull < -32768);
      end
      4'd2:  e.res = a | b;
      4'd3:  e.res = a & b;
      4'd4:  e.res = a ^ b;
      4'd5:  e.res = ~(a | b);
      4'd6:  e.res = ~(a & b);
      4'd7:  e.res = ~(a ^ b);
      4'd8, 4'd9: begin
        e.res = (n >= W) ? '0 : (a >> n);
        if (n > 0) begin e.cy = a[n-1]; e.off = n; end
      end
      4'd10: begin
        e.res = (n >= W) ? '0 : (a << n);
        if (n > 0) begin e.cy = a[W-n]; e.off = n; end
      end
      4'd11: begin
        e.res = $signed(a) >>> n;
        if (n > 0) begin e.cy = a[n-1]; e.off = n; end
      end
      4'd12: begin
        n = int'(b % W);
        e.res = (n == 0) ? a : ((a << n) | (a >> (W - n)));
        if (n > 0) begin e.cy = a[W-n]; e.off = n; end
      end
      4'd13: e.res = ~a;
      4'd14: begin
        full  = longint'(a) * longint'(b);
        e.res = full[W-1:0];
        e.cy  = ((full >> W) != 0);
        e.off = W;
      end
      default: e.res = b;
    endcase
    e.z = (e.res == '0);
    e.n = e.res[W-1];
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic applyStimulus(input logic [3:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic c);
    exp_t e;
    int guard = 0;
    alu_sel = sel; a_in = a; b_in = b; c_in = c; in_valid = 1;
    #1;
    while (!in_ready && guard < 300) begin
      @(negedge clk); #1; guard++;
    end
    checkOutput("accept_wait", 64'(in_ready), 64'(1));
    if (!in_ready) begin
      in_valid = 0;
      @(negedge clk);
      return;
    end
    e = model(sel, a, b, c);
    e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 0;
    a_in = W'($urandom); b_in = W'($urandom); alu_sel = 4'($urandom); c_in = 1'($urandom);
  endtask

  task automatic waitDrain();
    int g = 0;
    while (sb.size() != 0 && g < 600) begin
      @(negedge clk); g++;
    end
    checkOutput("drain", 64'(sb.size()), 64'(0));
  endtask

  // Monitor: compares the head entry every cycle a result is shown, pops on handshake.
  initial begin
    forever begin
      @(negedge clk); #2;
      if (out_valid) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL unexpected_result: got out_valid=1 out=%h, want out_valid=0", out);
        end else begin
          head = sb[0];
          if (!pending) begin
            pending = 1;
            checkOutput("latency", 64'(cyc - head.acc), 64'(head.off));
          end
          checkOutput("result", {out, c_out, zero, neg, ovf},
                      {head.res, head.cy, head.z, head.n, head.v});
          if (out_ready) begin
            void'(sb.pop_front());
            pending = 0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, want test end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1; in_valid = 0; alu_sel = 0; a_in = 0; b_in = 0; c_in = 0;
    readyForce = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    checkOutput("reset_state", {out, c_out, zero, neg, ovf, out_valid, busy, in_ready},
                {16'h0, 4'b0, 1'b0, 1'b0, 1'b1});
    @(negedge clk);

    applyStimulus(4'd0, 16'hFFFF, 16'h0001, 1'b0);
    applyStimulus(4'd1, 16'h0005, 16'h0007, 1'b1);
    applyStimulus(4'd0, 16'h7FFF, 16'h0001, 1'b0);
    applyStimulus(4'd10, 16'h0001, 16'd4, 1'b0);
    applyStimulus(4'd8, 16'hABCD, 16'd20, 1'b0);
    applyStimulus(4'd11, 16'h8000, 16'd3, 1'b0);
    applyStimulus(4'd12, 16'h8001, 16'd17, 1'b0);

    applyStimulus(4'd14, 16'h0100, 16'h0101, 1'b0);
    repeat (W) begin
      #1 checkOutput("mul_busy", {busy, in_ready}, 2'b10);
      @(negedge clk);
    end
    #1 checkOutput("mul_done", {busy, out_valid}, 2'b01);
    @(negedge clk);

    waitDrain();
    readyForce = 0;
    applyStimulus(4'd0, 16'h1234, 16'h4321, 1'b1);
    repeat (3) begin
      #1 checkOutput("stall_in_ready", 64'(in_ready), 64'(0));
      @(negedge clk);
    end
    readyForce = 1;
    repeat (4) applyStimulus(4'd2, W'($urandom), W'($urandom), 1'b0);

    waitDrain();
    applyStimulus(4'd14, W'($urandom), W'($urandom), 1'b0);
    repeat (4) @(negedge clk);
    rst = 1;
    #1 checkOutput("rst_mid_mul", {out_valid, busy, in_ready}, 3'b001);
    sb.delete();
    pending = 0;
    @(negedge clk);
    rst = 0;
    repeat (W + 4) @(negedge clk);
    #1 checkOutput("rst_no_result", 64'(out_valid), 64'(0));
    @(negedge clk);
    applyStimulus(4'd0, 16'h0010, 16'h0020, 1'b0);
    waitDrain();

    randReady = 1;
    repeat (150) begin
      logic [W-1:0] rb;
      rb = ($urandom_range(0, 1) != 0) ? W'($urandom) : W'($urandom_range(0, 20));
      applyStimulus(4'($urandom_range(0, 15)), W'($urandom), rb, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    randReady = 0;
    readyForce = 1;
    waitDrain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
